multi_channel_timer: RTL and testbench
======================================

// Module: multi_channel_timer
// PURPOSE
//  Parametrised successor to the single egg-timer datapath. It provides NUM_CH independent BCD
//  mm:ss countdown channels, all sharing one 1 Hz tick. A single command port loads, starts,
//  pauses, clears and acknowledges each channel. Each channel has a sticky expiry flag, and
//  AUTO_RELOAD gives repeating timers. The block sits between the clock divider (tick) and the
//  7-segment driver, which reads one channel through the disp_ch/disp_time readback.
// PARAMETERS
//  NUM_CH      4  number of independent countdown channels (1..16)
//  CH_W        2  channel index width; must satisfy 2**CH_W >= NUM_CH
//  AUTO_RELOAD 0  1: on expiry, reload the stored LOAD value and keep running; 0: stop at 00:00
// PORTS
//  CLK100MHZ  in   1        system clock; all logic on the rising edge
//  reset      in   1        synchronous, active-low reset
//  tick       in   1        1 Hz single-cycle enable pulse (pulse_1Hz)
//  cmd_valid  in   1        command strobe, one cycle per command
//  cmd_ready  out  1        command accept; command is taken when cmd_valid && cmd_ready
//  cmd_ch     in   CH_W     target channel
//  cmd_op     in   3        0 NOP, 1 LOAD, 2 START, 3 PAUSE, 4 CLEAR, 5 ACK, 6-7 reserved
//  cmd_time   in   16       LOAD value, BCD {min_tens, min_ones, sec_tens, sec_ones}
//  cmd_err    out  1        one-cycle pulse: the accepted command was rejected
//  disp_ch    in   CH_W     channel selected for readback
//  disp_time  out  16       BCD time of disp_ch, registered
//  running    out  NUM_CH   per-channel running flag
//  expired    out  NUM_CH   per-channel sticky expiry flag
//  alarm      out  1        OR of expired; drives Audio endtime
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//   - every channel's count and stored load value = 16'h0000
//   - running = 0, expired = 0, cmd_err = 0, disp_time = 0, cmd_ready = 0
//   - cmd_ready goes to 1 on the first clock after reset releases and stays 1
//  Per-channel state machine: IDLE (stopped), RUN, DONE (stopped at 00:00, expired = 1).
//  Commands take effect on the clock edge where they are accepted:
//   - LOAD: store cmd_time as the load value and the count; clear expired; keep the current
//     running state. If any digit > 9 or sec_tens > 5, reject: cmd_err = 1, no state change.
//   - START: IDLE -> RUN. Rejected with cmd_err = 1 if count == 0000 or cmd_ch >= NUM_CH.
//     START while in RUN is a no-op with no error.
//   - PAUSE: RUN -> IDLE; count held. No-op in other states.
//   - CLEAR: count = 0, load value = 0, running = 0, expired = 0; state -> IDLE.
//   - ACK: expired = 0; DONE -> IDLE. Count is unchanged.
//   - Reserved op, or any op with cmd_ch >= NUM_CH: cmd_err = 1, no state change.
//  Tick, for every channel in RUN on the edge where tick = 1:
//   - BCD decrement by one second, with borrows sec_ones 0->9, sec_tens 0->5, min_ones 0->9.
//   - If the pre-decrement count was 0001:
//     AUTO_RELOAD=0: count = 0000, running = 0, expired = 1, state -> DONE.
//     AUTO_RELOAD=1: count = load value, running stays 1, expired = 1.
//   - Latency: count and flags update on the same edge that samples tick.
//  Simultaneous command and tick:
//   - An accepted command on channel c overrides the tick for c in that cycle; c does not
//     decrement. All other channels tick normally.
//   - Exception: PAUSE applied with tick leaves the count un-decremented.
//  Limits: maximum count 99:59. The count never wraps below 00:00.
//  Readback: disp_time = count[disp_ch], registered, one cycle latency; out-of-range disp_ch
//  returns 0.
//  Reset mid-countdown aborts all channels immediately; no expiry is signalled.
// TESTING
//  T1 LOAD ch0 0105, START, 65 ticks -> count 0104,...,0100,0059,...,0000; expired[0]=1 on 65th tick, running[0]=0, alarm=1
//  T2 LOAD ch1 0070 (sec_tens=7) -> cmd_err pulses 1 cycle; count[1] stays 0000; START ch1 -> cmd_err again
//  T3 ch2 running at 0030, PAUSE coincident with tick -> count stays 0030, running[2]=0; other running channels decrement
//  T4 AUTO_RELOAD=1: LOAD ch3 0002, START, 2 ticks -> count 0002 again, expired[3]=1, running[3]=1; ACK -> expired[3]=0, still running
//  T5 four channels running, reset=0 for 1 cycle mid-count -> all counts 0, running=0, expired=0, cmd_ready=0 then 1 the next cycle
//  T6 ch0 in DONE, ACK -> running=0, expired[0]=0, alarm=0; disp_ch=0 -> disp_time=0000 one cycle later

Source files
------------

// File: rtl/multi_channel_timer.sv
// NUM_CH independent BCD mm:ss countdown channels sharing one 1 Hz tick, driven through a
// single command port, with sticky expiry flags, optional auto-reload and a registered readback.
module multi_channel_timer #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int AUTO_RELOAD = 0
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              tick,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [2:0]        cmd_op,
    input  logic [15:0]       cmd_time,
    output logic              cmd_err,
    input  logic [CH_W-1:0]   disp_ch,
    output logic [15:0]       disp_time,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] expired,
    output logic              alarm
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} ch_state_e;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_START = 3'd2,
        OP_PAUSE = 3'd3,
        OP_CLEAR = 3'd4,
        OP_ACK   = 3'd5
    } cmd_op_e;

    ch_state_e         state_q   [NUM_CH];
    ch_state_e         state_d   [NUM_CH];
    logic [15:0]       count_q   [NUM_CH];
    logic [15:0]       count_d   [NUM_CH];
    logic [15:0]       load_q    [NUM_CH];
    logic [15:0]       load_d    [NUM_CH];
    logic [NUM_CH-1:0] expired_q, expired_d;
    logic              cmd_ready_q;
    logic              cmd_err_q, cmd_err_d;
    logic [15:0]       disp_time_q, disp_time_d;

    logic              accept;
    logic              ch_ok;
    logic [NUM_CH-1:0] hit;
    logic [15:0]       sel_count;
    ch_state_e         sel_state;

    function automatic logic bcd_valid(input logic [15:0] t);
        return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    // Only called with a count above 00:01, so the minute tens never borrow below zero.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] d;
        d = t;
        if (t[3:0] != 4'd0) begin
            d[3:0] = t[3:0] - 4'd1;
        end else begin
            d[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                d[7:4] = t[7:4] - 4'd1;
            end else begin
                d[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    d[11:8] = t[11:8] - 4'd1;
                end else begin
                    d[11:8]  = 4'd9;
                    d[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return d;
    endfunction

    always_comb begin
        accept    = cmd_valid && cmd_ready_q;
        ch_ok     = (32'(cmd_ch) < NUM_CH);
        hit       = '0;
        sel_count = 16'h0000;
        sel_state = ST_IDLE;
        for (int c = 0; c < NUM_CH; c++) begin
            if (accept && ch_ok && (cmd_ch == CH_W'(c))) begin
                hit[c]    = 1'b1;
                sel_count = count_q[c];
                sel_state = state_q[c];
            end
        end

        cmd_err_d = 1'b0;
        if (accept) begin
            if (!ch_ok) begin
                cmd_err_d = 1'b1;
            end else begin
                case (cmd_op)
                    OP_NOP, OP_PAUSE, OP_CLEAR, OP_ACK: cmd_err_d = 1'b0;
                    OP_LOAD:  cmd_err_d = !bcd_valid(cmd_time);
                    OP_START: cmd_err_d = (sel_state != ST_RUN) && (sel_count == 16'h0000);
                    default:  cmd_err_d = 1'b1;
                endcase
            end
        end
    end

    // A command addressed to a channel wins over the tick for that channel in the same cycle.
    always_comb begin
        expired_d = expired_q;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            count_d[c] = count_q[c];
            load_d[c]  = load_q[c];
            if (hit[c]) begin
                if (!cmd_err_d) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            count_d[c]   = cmd_time;
                            load_d[c]    = cmd_time;
                            expired_d[c] = 1'b0;
                            if (state_q[c] == ST_DONE) state_d[c] = ST_IDLE;
                        end
                        OP_START: if (state_q[c] == ST_IDLE) state_d[c] = ST_RUN;
                        OP_PAUSE: if (state_q[c] == ST_RUN) state_d[c] = ST_IDLE;
                        OP_CLEAR: begin
                            count_d[c]   = 16'h0000;
                            load_d[c]    = 16'h0000;
                            expired_d[c] = 1'b0;
                            state_d[c]   = ST_IDLE;
                        end
                        OP_ACK: begin
                            expired_d[c] = 1'b0;
                            if (state_q[c] == ST_DONE) state_d[c] = ST_IDLE;
                        end
                        default: ;
                    endcase
                end
            end else if (tick && (state_q[c] == ST_RUN)) begin
                if (count_q[c] == 16'h0001) begin
                    expired_d[c] = 1'b1;
                    if (AUTO_RELOAD != 0) begin
                        count_d[c] = load_q[c];
                    end else begin
                        count_d[c] = 16'h0000;
                        state_d[c] = ST_DONE;
                    end
                end else if (count_q[c] != 16'h0000) begin
                    count_d[c] = bcd_dec(count_q[c]);
                end
            end
        end

        disp_time_d = 16'h0000;
        for (int c = 0; c < NUM_CH; c++) begin
            if (disp_ch == CH_W'(c)) disp_time_d = count_q[c];
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
                count_q[c] <= 16'h0000;
                load_q[c]  <= 16'h0000;
            end
            expired_q   <= '0;
            cmd_ready_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            disp_time_q <= 16'h0000;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                count_q[c] <= count_d[c];
                load_q[c]  <= load_d[c];
            end
            expired_q   <= expired_d;
            cmd_ready_q <= 1'b1;
            cmd_err_q   <= cmd_err_d;
            disp_time_q <= disp_time_d;
        end
    end

    always_comb begin
        running = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            running[c] = (state_q[c] == ST_RUN);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cmd_err   = cmd_err_q;
    assign disp_time = disp_time_q;
    assign expired   = expired_q;
    assign alarm     = |expired_q;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer: one stop-at-zero instance and one auto-reload
// instance share the same stimulus; expected values are hand-derived or from a seconds model.
module tb_multi_channel_timer;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_START = 3'd2;
    localparam logic [2:0] OP_PAUSE = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;
    localparam logic [2:0] OP_ACK   = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        cmdValid;
    logic [1:0]  cmdCh;
    logic [2:0]  cmdOp;
    logic [15:0] cmdTime;
    logic [1:0]  dispCh;

    logic        cmdReady, cmdReadyAr;
    logic        cmdErr, cmdErrAr;
    logic [15:0] dispTime, dispTimeAr;
    logic [3:0]  running, runningAr;
    logic [3:0]  expired, expiredAr;
    logic        alarm, alarmAr;

    int testCount = 0;
    int failCount = 0;
    logic [15:0] v, vAr;

    multi_channel_timer #(.NUM_CH(4), .CH_W(2), .AUTO_RELOAD(0)) dut (
        .CLK100MHZ(clk), .reset(reset), .tick(tick),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_ch(cmdCh), .cmd_op(cmdOp),
        .cmd_time(cmdTime), .cmd_err(cmdErr), .disp_ch(dispCh), .disp_time(dispTime),
        .running(running), .expired(expired), .alarm(alarm)
    );

    multi_channel_timer #(.NUM_CH(4), .CH_W(2), .AUTO_RELOAD(1)) dutAr (
        .CLK100MHZ(clk), .reset(reset), .tick(tick),
        .cmd_valid(cmdValid), .cmd_ready(cmdReadyAr), .cmd_ch(cmdCh), .cmd_op(cmdOp),
        .cmd_time(cmdTime), .cmd_err(cmdErrAr), .disp_ch(dispCh), .disp_time(dispTimeAr),
        .running(runningAr), .expired(expiredAr), .alarm(alarmAr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int s);
        int m, ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge so they are stable at the next one.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] ch,
                                 input logic [15:0] t, input logic withTick);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdCh    = ch;
        cmdTime  = t;
        tick     = withTick;
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        tick     = 1'b0;
    endtask

    task automatic applyTick();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic readCount(input logic [1:0] ch, output logic [15:0] c, output logic [15:0] cAr);
        dispCh = ch;
        @(posedge clk);
        #1;
        c   = dispTime;
        cAr = dispTimeAr;
    endtask

    initial begin
        reset    = 1'b0;
        tick     = 1'b0;
        cmdValid = 1'b0;
        cmdCh    = 2'd0;
        cmdOp    = OP_NOP;
        cmdTime  = 16'h0000;
        dispCh   = 2'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst cmd_ready", 16'(cmdReady), 16'd0);
        checkOutput("rst running", 16'(running), 16'd0);
        checkOutput("rst expired", 16'(expired), 16'd0);
        checkOutput("rst cmd_err", 16'(cmdErr), 16'd0);
        checkOutput("rst disp_time", dispTime, 16'h0000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst ready after release", 16'(cmdReady), 16'd1);

        // T1: 01:05 counts down through the minute borrow to expiry.
        applyStimulus(OP_LOAD, 2'd0, 16'h0105, 1'b0);
        checkOutput("t1 load err", 16'(cmdErr), 16'd0);
        applyStimulus(OP_START, 2'd0, 16'h0000, 1'b0);
        checkOutput("t1 start err", 16'(cmdErr), 16'd0);
        checkOutput("t1 running", 16'(running), 16'b0001);
        for (int i = 1; i <= 65; i++) begin
            applyTick();
            readCount(2'd0, v, vAr);
            checkOutput($sformatf("t1 tick%0d", i), v, toBcd(65 - i));
        end
        checkOutput("t1 expired", 16'(expired), 16'b0001);
        checkOutput("t1 running end", 16'(running), 16'd0);
        checkOutput("t1 alarm", 16'(alarm), 16'd1);
        checkOutput("t1 ar reload", vAr, 16'h0105);
        applyTick();
        readCount(2'd0, v, vAr);
        checkOutput("t1 no wrap", v, 16'h0000);

        // T2: invalid BCD loads and START on an empty channel are rejected.
        applyStimulus(OP_LOAD, 2'd1, 16'h0070, 1'b0);
        checkOutput("t2 load err", 16'(cmdErr), 16'd1);
        @(posedge clk);
        #1;
        checkOutput("t2 err pulse", 16'(cmdErr), 16'd0);
        readCount(2'd1, v, vAr);
        checkOutput("t2 count kept", v, 16'h0000);
        applyStimulus(OP_START, 2'd1, 16'h0000, 1'b0);
        checkOutput("t2 start err", 16'(cmdErr), 16'd1);
        checkOutput("t2 not running", 16'(running[1]), 16'd0);
        applyStimulus(OP_LOAD, 2'd1, 16'h00A0, 1'b0);
        checkOutput("t2 digit err", 16'(cmdErr), 16'd1);
        applyStimulus(3'd6, 2'd1, 16'h0000, 1'b0);
        checkOutput("t2 reserved err", 16'(cmdErr), 16'd1);

        // T6: ACK a finished channel.
        applyStimulus(OP_ACK, 2'd0, 16'h0000, 1'b0);
        checkOutput("t6 ack err", 16'(cmdErr), 16'd0);
        checkOutput("t6 running0", 16'(running[0]), 16'd0);
        checkOutput("t6 expired", 16'(expired), 16'd0);
        checkOutput("t6 alarm", 16'(alarm), 16'd0);
        readCount(2'd0, v, vAr);
        checkOutput("t6 disp", v, 16'h0000);

        // T3: PAUSE on ch2 coincident with a tick; ch1 keeps counting.
        applyStimulus(OP_LOAD, 2'd2, 16'h0030, 1'b0);
        applyStimulus(OP_START, 2'd2, 16'h0000, 1'b0);
        applyStimulus(OP_LOAD, 2'd1, 16'h0010, 1'b0);
        applyStimulus(OP_START, 2'd1, 16'h0000, 1'b0);
        applyStimulus(OP_PAUSE, 2'd2, 16'h0000, 1'b1);
        checkOutput("t3 running2", 16'(running[2]), 16'd0);
        checkOutput("t3 running1", 16'(running[1]), 16'd1);
        readCount(2'd2, v, vAr);
        checkOutput("t3 ch2 held", v, 16'h0030);
        readCount(2'd1, v, vAr);
        checkOutput("t3 ch1 ticked", v, 16'h0009);

        // T4: 00:02 reloads on the auto-reload instance and stops on the other.
        applyStimulus(OP_LOAD, 2'd3, 16'h0002, 1'b0);
        applyStimulus(OP_START, 2'd3, 16'h0000, 1'b0);
        applyTick();
        readCount(2'd3, v, vAr);
        checkOutput("t4 ar tick1", vAr, 16'h0001);
        checkOutput("t4 tick1", v, 16'h0001);
        applyTick();
        readCount(2'd3, v, vAr);
        checkOutput("t4 ar reload", vAr, 16'h0002);
        checkOutput("t4 ar expired3", 16'(expiredAr[3]), 16'd1);
        checkOutput("t4 ar running3", 16'(runningAr[3]), 16'd1);
        checkOutput("t4 stop count", v, 16'h0000);
        checkOutput("t4 stop expired3", 16'(expired[3]), 16'd1);
        checkOutput("t4 stop running3", 16'(running[3]), 16'd0);
        applyStimulus(OP_ACK, 2'd3, 16'h0000, 1'b0);
        checkOutput("t4 ar ack expired3", 16'(expiredAr[3]), 16'd0);
        checkOutput("t4 ar ack running3", 16'(runningAr[3]), 16'd1);
        readCount(2'd1, v, vAr);
        checkOutput("t4 ch1", v, 16'h0007);

        // T5: all four channels running, then a one-cycle reset.
        applyStimulus(OP_LOAD, 2'd0, 16'h0200, 1'b0);
        applyStimulus(OP_START, 2'd0, 16'h0000, 1'b0);
        applyStimulus(OP_START, 2'd2, 16'h0000, 1'b0);
        applyStimulus(OP_LOAD, 2'd3, 16'h0100, 1'b0);
        applyStimulus(OP_START, 2'd3, 16'h0000, 1'b0);
        checkOutput("t5 all running", 16'(running), 16'b1111);
        checkOutput("t5 ar all running", 16'(runningAr), 16'b1111);
        applyTick();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("t5 rst ready", 16'(cmdReady), 16'd0);
        checkOutput("t5 rst running", 16'(running), 16'd0);
        checkOutput("t5 rst ar running", 16'(runningAr), 16'd0);
        checkOutput("t5 rst expired", 16'(expired), 16'd0);
        checkOutput("t5 rst alarm", 16'(alarm), 16'd0);
        @(posedge clk);
        #1;
        checkOutput("t5 ready back", 16'(cmdReady), 16'd1);
        for (int c = 0; c < 4; c++) begin
            readCount(2'(c), v, vAr);
            checkOutput($sformatf("t5 count%0d", c), v, 16'h0000);
            checkOutput($sformatf("t5 ar count%0d", c), vAr, 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
